hdb3_decoder: RTL and testbench
===============================

# hdb3_decoder

Downstream stage of HDB3 clock recovery: consumes the 8-bit AD sample stream plus the recovered symbol clock `clk_rec`, slices each symbol into a ternary value (+1 / 0 / -1), removes HDB3 substitutions (000V and B00V), and emits the NRZ bit stream with a one-cycle valid strobe. It runs entirely in the `clk_in` sample domain and feeds the frame or BER logic downstream.

## Interface
- `SAMPLE_DLY`, default 0: `clk_in` cycles between the detected `clk_rec` rising edge and the sampling of `indata_8`. Range 0..7.
- `TH_HI`, default 8'h58: `indata_8` ≥ TH_HI → +1.
- `TH_Z_HI`, default 8'h3f: upper bound of the zero band.
- `TH_Z_LO`, default 8'h30: lower bound of the zero band.
- `TH_LO`, default 8'h0f: `indata_8` ≤ TH_LO → -1.
- `clk_in` input 1: AD sample clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `indata_8` input 8: AD sample.
- `clk_rec` input 1: recovered symbol clock, registered in the `clk_in` domain, so no synchronizer is required.
- `dout` output 1: decoded NRZ bit.
- `dout_valid` output 1: one-cycle pulse per decoded bit.
- `sym_err` output 1: one-cycle pulse when the sample falls outside all three bands.
- `viol_cnt` output 16: count of detected V symbols, saturating at 16'hffff.

## Operation
- Edge detect:
  - Register `clk_rec` into `clk_rec_d`.
  - A rising edge is `clk_rec & ~clk_rec_d`.
  - When SAMPLE_DLY = 0, the strobe is the edge cycle itself.
  - Otherwise a 3-bit delay counter loads on the edge and raises the strobe when it reaches SAMPLE_DLY.
  - An edge arriving while the counter is busy restarts it.
- Slicer, on strobe:
  - ≥TH_HI → POS.
  - ≤TH_LO → NEG.
  - TH_Z_LO..TH_Z_HI → ZERO.
  - Any other value → ZERO, and `sym_err` pulses.
- Symbol pipeline: a 4-entry shift register `s[0..3]` of 2-bit symbols plus per-entry occupancy. Each strobe shifts the new symbol into `s[0]`; `s[3]` leaves the pipeline.
- Polarity tracker:
  - `pol_last` (POS/NEG) plus `pol_valid`, both cleared at reset.
  - A nonzero incoming symbol with `pol_valid == 1` and the same polarity as `pol_last` is a violation V.
  - On V: the incoming symbol enters as ZERO, the entry that becomes `s[3]` after the shift is forced to ZERO (this clears B or leaves 0), and `viol_cnt` increments.
  - Every nonzero incoming symbol, V included, updates `pol_last` and sets `pol_valid`.
- Output: the bit leaving is 1 iff the departing `s[3]` is nonzero and occupied. `dout_valid` pulses only when the departing entry was occupied. The first 4 strobes after reset produce no output.
- A violation detected before 3 earlier symbols exist clears only the occupied entries in range. Unoccupied entries are never marked occupied by a clear.
- If `clk_rec` stops, no strobes occur and all state holds indefinitely.

## Timing
- Strobe at cycle T. The slice, shift, V detection and clear are all registered at edge T+1. `dout`, `dout_valid` and `sym_err` are valid during cycle T+1.
- Bit latency is 4 symbols plus 1 `clk_in`, plus SAMPLE_DLY after the `clk_rec` edge.
- `dout` holds its value between strobes. `dout_valid` and `sym_err` are high for exactly one cycle.
- Reset values, asserted at any time:
  - `dout`, `dout_valid`, `sym_err`: 0.
  - `viol_cnt`: 0.
  - Pipeline empty, `pol_valid` = 0, delay counter idle, `clk_rec_d` = 0.
- A `clk_rec` already high when reset is released is not treated as an edge.

## Structure
- Package `hdb3_pkg`:
  - Symbol encodings SYM_ZERO = 2'b00, SYM_POS = 2'b01, SYM_NEG = 2'b11.
  - Default threshold constants.
- Sub-module `hdb3_slicer`: combinational threshold compare producing the symbol and the error flag. The decoder instantiates it once.

## Test plan
- Reset, then symbols POS(0xff) ZERO(0x38) NEG(0x00) ZERO ZERO POS NEG, sampled with `clk_rec` toggling every 8 `clk_in` → `dout` sequence 1 0 1 0 0 1 1 after 4 strobes of fill; `viol_cnt` = 0.
- 000V case: POS, 0, 0, 0, POS(V), NEG → bits 1 0 0 0 0 1; `viol_cnt` = 1.
- B00V case: POS, NEG(B), 0, 0, NEG(V), POS → bits 1 0 0 0 0 1; `viol_cnt` = 1.
- Sample 0x20 at a strobe → `sym_err` pulses for 1 cycle and the symbol decodes as 0.
- SAMPLE_DLY = 3 → strobe occurs 3 cycles after each `clk_rec` rise. Assert `rst_n` low mid-stream → all outputs are 0 immediately; after release, 4 strobes pass before the first `dout_valid`.
- Force 65536+ violations → `viol_cnt` holds at 16'hffff.

Source files
------------

// File: rtl/hdb3_pkg.sv
// Shared symbol encodings and default slicer thresholds for the HDB3 decode path.
package hdb3_pkg;

    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_POS  = 2'b01,
        SYM_NEG  = 2'b11
    } sym_e;

    localparam logic [7:0]  TH_HI_DEF   = 8'h58;
    localparam logic [7:0]  TH_Z_HI_DEF = 8'h3f;
    localparam logic [7:0]  TH_Z_LO_DEF = 8'h30;
    localparam logic [7:0]  TH_LO_DEF   = 8'h0f;
    localparam logic [15:0] VIOL_MAX    = 16'hffff;

endpackage

// File: rtl/hdb3_decoder_if.sv
// Sample/symbol-clock inputs and decoded outputs of the HDB3 decoder.
interface hdb3_decoder_if;
    import hdb3_pkg::*;

    logic        clk_rec;
    logic [7:0]  indata_8;
    logic        dout;
    logic        dout_valid;
    logic        sym_err;
    logic [15:0] viol_cnt;

    modport master (
        output clk_rec, indata_8,
        input  dout, dout_valid, sym_err, viol_cnt
    );

    modport slave (
        input  clk_rec, indata_8,
        output dout, dout_valid, sym_err, viol_cnt
    );

endinterface

// File: rtl/hdb3_slicer.sv
// Combinational ternary slicer: maps one AD sample to +1 / 0 / -1 and flags
// samples that fall between the bands.
module hdb3_slicer
    import hdb3_pkg::*;
#(
    parameter logic [7:0] TH_HI   = TH_HI_DEF,
    parameter logic [7:0] TH_Z_HI = TH_Z_HI_DEF,
    parameter logic [7:0] TH_Z_LO = TH_Z_LO_DEF,
    parameter logic [7:0] TH_LO   = TH_LO_DEF
) (
    input  logic [7:0] sample,
    output sym_e       sym,
    output logic       err
);

    always_comb begin
        sym = SYM_ZERO;
        err = 1'b0;
        if (sample >= TH_HI) begin
            sym = SYM_POS;
        end else if (sample <= TH_LO) begin
            sym = SYM_NEG;
        end else if ((sample >= TH_Z_LO) && (sample <= TH_Z_HI)) begin
            sym = SYM_ZERO;
        end else begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/hdb3_decoder.sv
// HDB3 decoder: strobes on recovered clk_rec edges, slices samples, strips
// 000V/B00V substitutions through a 4-symbol pipeline and emits NRZ bits.
module hdb3_decoder
    import hdb3_pkg::*;
#(
    parameter int unsigned SAMPLE_DLY = 0,
    parameter logic [7:0]  TH_HI      = TH_HI_DEF,
    parameter logic [7:0]  TH_Z_HI    = TH_Z_HI_DEF,
    parameter logic [7:0]  TH_Z_LO    = TH_Z_LO_DEF,
    parameter logic [7:0]  TH_LO      = TH_LO_DEF
) (
    input  logic          clk_in,
    input  logic          rst_n,
    hdb3_decoder_if.slave bus
);

    localparam logic [2:0] DLY = 3'(SAMPLE_DLY);

    logic        clk_rec_d_q, clk_rec_d_d;
    logic        armed_q, armed_d;
    logic [2:0]  dly_cnt_q, dly_cnt_d;
    logic        dly_busy_q, dly_busy_d;
    sym_e        s_q [4];
    sym_e        s_d [4];
    logic [3:0]  occ_q, occ_d;
    sym_e        pol_last_q, pol_last_d;
    logic        pol_valid_q, pol_valid_d;
    logic        dout_q, dout_d;
    logic        dout_valid_q, dout_valid_d;
    logic        sym_err_q, sym_err_d;
    logic [15:0] viol_cnt_q, viol_cnt_d;

    logic        rec_rise;
    logic        strobe;
    sym_e        slice_sym;
    logic        slice_err;
    logic        is_v;

    hdb3_slicer #(
        .TH_HI   (TH_HI),
        .TH_Z_HI (TH_Z_HI),
        .TH_Z_LO (TH_Z_LO),
        .TH_LO   (TH_LO)
    ) u_slicer (
        .sample (bus.indata_8),
        .sym    (slice_sym),
        .err    (slice_err)
    );

    // armed_q masks the first cycle after reset so a clk_rec already high is not an edge
    assign rec_rise = bus.clk_rec & ~clk_rec_d_q & armed_q;

    always_comb begin
        clk_rec_d_d = bus.clk_rec;
        armed_d     = 1'b1;
        dly_cnt_d   = dly_cnt_q;
        dly_busy_d  = dly_busy_q;
        strobe      = 1'b0;

        if (SAMPLE_DLY == 0) begin
            strobe = rec_rise;
        end else begin
            strobe = dly_busy_q && (dly_cnt_q == DLY);
            if (strobe) begin
                dly_busy_d = 1'b0;
            end else if (dly_busy_q) begin
                dly_cnt_d = dly_cnt_q + 3'd1;
            end
            if (rec_rise) begin
                dly_busy_d = 1'b1;
                dly_cnt_d  = 3'd1;
            end
        end
    end

    assign is_v = (slice_sym != SYM_ZERO) && pol_valid_q && (slice_sym == pol_last_q);

    always_comb begin
        s_d          = s_q;
        occ_d        = occ_q;
        pol_last_d   = pol_last_q;
        pol_valid_d  = pol_valid_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sym_err_d    = 1'b0;
        viol_cnt_d   = viol_cnt_q;

        if (strobe) begin
            dout_d       = occ_q[3] && (s_q[3] != SYM_ZERO);
            dout_valid_d = occ_q[3];
            sym_err_d    = slice_err;

            // The V clears the entry landing in s[3] (B or 0); occupancy is only shifted.
            s_d[0] = is_v ? SYM_ZERO : slice_sym;
            s_d[1] = s_q[0];
            s_d[2] = s_q[1];
            s_d[3] = is_v ? SYM_ZERO : s_q[2];
            occ_d  = {occ_q[2:0], 1'b1};

            if (slice_sym != SYM_ZERO) begin
                pol_last_d  = slice_sym;
                pol_valid_d = 1'b1;
            end
            if (is_v && (viol_cnt_q != VIOL_MAX)) begin
                viol_cnt_d = viol_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            clk_rec_d_q  <= 1'b0;
            armed_q      <= 1'b0;
            dly_cnt_q    <= '0;
            dly_busy_q   <= 1'b0;
            s_q          <= '{default: SYM_ZERO};
            occ_q        <= '0;
            pol_last_q   <= SYM_ZERO;
            pol_valid_q  <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            sym_err_q    <= 1'b0;
            viol_cnt_q   <= '0;
        end else begin
            clk_rec_d_q  <= clk_rec_d_d;
            armed_q      <= armed_d;
            dly_cnt_q    <= dly_cnt_d;
            dly_busy_q   <= dly_busy_d;
            s_q          <= s_d;
            occ_q        <= occ_d;
            pol_last_q   <= pol_last_d;
            pol_valid_q  <= pol_valid_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sym_err_q    <= sym_err_d;
            viol_cnt_q   <= viol_cnt_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.sym_err    = sym_err_q;
    assign bus.viol_cnt   = viol_cnt_q;

endmodule

// File: tb/tb_hdb3_decoder.sv
// Directed bench for hdb3_decoder: two instances (SAMPLE_DLY 0 and 3) share
// one symbol stream; each only sees the real sample at its own strobe offset.
module tb_hdb3_decoder;

    localparam logic [7:0] FILL = 8'h20;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic q0[$];
    logic q3[$];
    int   err0 = 0;
    int   err3 = 0;

    hdb3_decoder_if if0 ();
    hdb3_decoder_if if3 ();

    hdb3_decoder #(.SAMPLE_DLY(0)) dut0 (.clk_in(clk_in), .rst_n(rst_n), .bus(if0));
    hdb3_decoder #(.SAMPLE_DLY(3)) dut3 (.clk_in(clk_in), .rst_n(rst_n), .bus(if3));

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (rst_n) begin
            if (if0.dout_valid) q0.push_back(if0.dout);
            if (if3.dout_valid) q3.push_back(if3.dout);
            if (if0.sym_err) err0++;
            if (if3.sym_err) err3++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        q0.delete();
        q3.delete();
        err0 = 0;
        err3 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n        = 1'b0;
        if0.clk_rec  = 1'b0;
        if3.clk_rec  = 1'b0;
        if0.indata_8 = FILL;
        if3.indata_8 = FILL;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);
        clear_mon();
    endtask

    // One symbol period of 8 clk_in cycles; clk_rec high for the first 4.
    task automatic send(input logic [7:0] v);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            if0.clk_rec  = (k < 4);
            if3.clk_rec  = (k < 4);
            if0.indata_8 = (k == 0) ? v : FILL;
            if3.indata_8 = (k == 3) ? v : FILL;
        end
    endtask

    task automatic flush();
        repeat (4) send(8'h38);
    endtask

    task automatic check_bits(input string tag, input int n, input logic [15:0] exp);
        logic [15:0] g0;
        logic [15:0] g3;
        g0 = '0;
        g3 = '0;
        foreach (q0[i]) g0 = {g0[14:0], q0[i]};
        foreach (q3[i]) g3 = {g3[14:0], q3[i]};
        check({tag, "_cnt0"}, 32'(q0.size()), 32'(n));
        check({tag, "_bits0"}, 32'(g0), 32'(exp));
        check({tag, "_cnt3"}, 32'(q3.size()), 32'(n));
        check({tag, "_bits3"}, 32'(g3), 32'(exp));
    endtask

    initial begin
        if0.clk_rec  = 1'b0;
        if3.clk_rec  = 1'b0;
        if0.indata_8 = FILL;
        if3.indata_8 = FILL;

        do_reset();
        check("rst_dout",  32'(if0.dout),       32'd0);
        check("rst_valid", 32'(if0.dout_valid), 32'd0);
        check("rst_err",   32'(if0.sym_err),    32'd0);
        check("rst_viol",  32'(if0.viol_cnt),   32'd0);

        // Plain AMI: no violations
        send(8'hff); send(8'h38); send(8'h00); send(8'h38);
        send(8'h38); send(8'hff); send(8'h00);
        flush();
        check_bits("ami", 7, 16'h0053);
        check("ami_viol0", 32'(if0.viol_cnt), 32'd0);
        check("ami_viol3", 32'(if3.viol_cnt), 32'd0);
        check("ami_err0",  32'(err0), 32'd0);
        check("ami_err3",  32'(err3), 32'd0);

        // 000V
        do_reset();
        send(8'hff); send(8'h38); send(8'h38); send(8'h38);
        send(8'hff); send(8'h00);
        flush();
        check_bits("v000", 6, 16'h0021);
        check("v000_viol0", 32'(if0.viol_cnt), 32'd1);
        check("v000_viol3", 32'(if3.viol_cnt), 32'd1);

        // B00V
        do_reset();
        send(8'hff); send(8'h00); send(8'h38); send(8'h38);
        send(8'h00); send(8'hff);
        flush();
        check_bits("b00v", 6, 16'h0021);
        check("b00v_viol0", 32'(if0.viol_cnt), 32'd1);
        check("b00v_viol3", 32'(if3.viol_cnt), 32'd1);

        // Band boundaries and out-of-band samples
        do_reset();
        send(8'h20); send(8'h40); send(8'h58); send(8'h0f);
        send(8'h30); send(8'h3f); send(8'h57); send(8'h10);
        flush();
        check_bits("band", 8, 16'h0030);
        check("band_err0",  32'(err0), 32'd4);
        check("band_err3",  32'(err3), 32'd4);
        check("band_viol0", 32'(if0.viol_cnt), 32'd0);

        // Asynchronous reset mid-stream, released while clk_rec is high
        do_reset();
        send(8'hff); send(8'hff); send(8'h00); send(8'hff); send(8'h00);
        check("pre_dout0", 32'(if0.dout),     32'd1);
        check("pre_dout3", 32'(if3.dout),     32'd1);
        check("pre_viol0", 32'(if0.viol_cnt), 32'd1);
        @(negedge clk_in);
        if0.clk_rec = 1'b1;
        if3.clk_rec = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("ar_dout0",  32'(if0.dout),       32'd0);
        check("ar_valid0", 32'(if0.dout_valid), 32'd0);
        check("ar_err0",   32'(if0.sym_err),    32'd0);
        check("ar_viol0",  32'(if0.viol_cnt),   32'd0);
        check("ar_dout3",  32'(if3.dout),       32'd0);
        check("ar_viol3",  32'(if3.viol_cnt),   32'd0);
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_in);
        if0.clk_rec = 1'b0;
        if3.clk_rec = 1'b0;
        @(negedge clk_in);
        clear_mon();
        send(8'hff); send(8'h00); send(8'hff); send(8'h00);
        check("fill_cnt0", 32'(q0.size()), 32'd0);
        check("fill_cnt3", 32'(q3.size()), 32'd0);
        check("fill_err0", 32'(err0), 32'd0);
        send(8'h38);
        check_bits("first", 1, 16'h0001);

        // Saturation: preload near the top, then repeat same-polarity marks
        do_reset();
        @(negedge clk_in);
        force dut0.viol_cnt_q = 16'hfffc;
        @(negedge clk_in);
        release dut0.viol_cnt_q;
        send(8'hff); send(8'hff); send(8'hff);
        check("sat_step", 32'(if0.viol_cnt), 32'h0000fffe);
        send(8'hff);
        check("sat_top", 32'(if0.viol_cnt), 32'h0000ffff);
        send(8'hff); send(8'hff);
        check("sat_hold", 32'(if0.viol_cnt), 32'h0000ffff);
        check("sat_viol3", 32'(if3.viol_cnt), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
